// File: rtl/coin_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coin_feeder_pkg
//  Description : Shared definitions for the coin feeder and the vending
//                machine it talks to: default count width, FSM state
//                encoding and the pulse-generator lane identifiers.
//  Revision    : 1.0  initial release
// ============================================================================
package coin_feeder_pkg;

    // Width of every coin / ticket count exchanged with the vending machine.
    localparam int c_dw = 8;

    // Lane selectors for the shared pulse generator.
    localparam logic c_lane_ten = 1'b0;
    localparam logic c_lane_one = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_TEN = 3'd1,
        ST_SEND_ONE = 3'd2,
        ST_DONE     = 3'd3,
        ST_COLLECT  = 3'd4,
        ST_REPORT   = 3'd5
    } feeder_state_t;

endpackage : coin_feeder_pkg
`default_nettype wire

// File: rtl/coin_feeder_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : coin_feeder_pulse_gen
//  Description : Emits a train of single-cycle pulses, each followed by GAP
//                low cycles, on one of two lanes. Reloaded once per coin type.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in   clock
//    rst    in   synchronous active-high reset
//    load   in   start a new train (takes priority over a running train)
//    lane   in   lane for the new train (0 = ten coins, 1 = one coins)
//    count  in   number of pulses in the new train (0 = no train)
//    pulse  out  registered pulse, one-hot by lane: [0] ten, [1] one
//    last   out  high in the final GAP cycle after the last pulse
// ============================================================================
module coin_feeder_pulse_gen
    import coin_feeder_pkg::*;
#(
    parameter int DW  = c_dw,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          lane,
    input  logic [DW-1:0] count,
    output logic [1:0]    pulse,
    output logic          last
);

    localparam int            c_gw  = $clog2(GAP) + 1;
    localparam logic [c_gw-1:0] c_gap = c_gw'(GAP);
    localparam logic [c_gw-1:0] c_one = c_gw'(1);

    logic            r_active;
    logic            r_lane;
    logic [1:0]      r_pulse;
    logic [DW-1:0]   r_remaining;   // pulses still to emit after the current one
    logic [c_gw-1:0] r_gap;         // low cycles left, including the current one

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active    <= 1'b0;
            r_lane      <= 1'b0;
            r_pulse     <= 2'b00;
            r_remaining <= '0;
            r_gap       <= '0;
        end else if (load) begin
            r_lane <= lane;
            if (count != '0) begin
                r_active    <= 1'b1;
                r_pulse     <= lane ? 2'b10 : 2'b01;
                r_remaining <= count - DW'(1);
                r_gap       <= c_gap;
            end else begin
                r_active    <= 1'b0;
                r_pulse     <= 2'b00;
                r_remaining <= '0;
                r_gap       <= '0;
            end
        end else if (r_active) begin
            if (r_pulse != 2'b00) begin
                r_pulse <= 2'b00;
                r_gap   <= c_gap;
            end else if (r_gap == c_one) begin
                if (r_remaining != '0) begin
                    r_pulse     <= r_lane ? 2'b10 : 2'b01;
                    r_remaining <= r_remaining - DW'(1);
                end else begin
                    r_active <= 1'b0;
                end
            end else begin
                r_gap <= r_gap - c_one;
            end
        end
    end

    assign pulse = r_pulse;
    assign last  = r_active && (r_pulse == 2'b00) && (r_gap == c_one)
                   && (r_remaining == '0);

endmodule : coin_feeder_pulse_gen
`default_nettype wire

// File: rtl/coin_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : coin_feeder
//  Description : Runs one purchase on a pulse-driven vending machine: sends
//                ten-unit then one-unit coin pulses, strobes done, then counts
//                returned ticket and change pulses until the lines go quiet
//                for TIMEOUT cycles and reports the totals.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk                 in   clock
//    rst                 in   synchronous active-high reset
//    start               in   run one purchase (honoured only when idle)
//    pay_ten / pay_one   in   coins of each kind to insert
//    ticket_pulse        in   ticket pulse train from the machine
//    coin_one_out_pulse  in   change pulse train from the machine
//    coin_ten_in_pulse   out  ten-coin insertion pulses
//    coin_one_in_pulse   out  one-coin insertion pulses
//    done                out  one-cycle end-of-payment strobe
//    busy                out  high whenever not idle
//    result_valid        out  one-cycle strobe, counts final
//    tickets_rcvd        out  ticket rising edges (saturating)
//    change_rcvd         out  change rising edges (saturating)
// ============================================================================
module coin_feeder
    import coin_feeder_pkg::*;
#(
    parameter int DW      = c_dw,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] pay_ten,
    input  logic [DW-1:0] pay_one,
    input  logic          ticket_pulse,
    input  logic          coin_one_out_pulse,
    output logic          coin_ten_in_pulse,
    output logic          coin_one_in_pulse,
    output logic          done,
    output logic          busy,
    output logic          result_valid,
    output logic [DW-1:0] tickets_rcvd,
    output logic [DW-1:0] change_rcvd
);

    localparam int              c_qw         = $clog2(TIMEOUT) + 1;
    localparam logic [c_qw-1:0] c_quiet_last = c_qw'(TIMEOUT - 1);
    localparam logic [DW-1:0]   c_count_max  = '1;

    feeder_state_t   r_state;
    feeder_state_t   w_state_next;

    logic [DW-1:0]   r_pay_one;
    logic            r_ticket_d;
    logic            r_change_d;
    logic [c_qw-1:0] r_quiet;
    logic            r_done;
    logic            r_busy;
    logic            r_result_valid;
    logic [DW-1:0]   r_tickets;
    logic [DW-1:0]   r_change;

    logic            w_pg_load;
    logic            w_pg_lane;
    logic [DW-1:0]   w_pg_count;
    logic [1:0]      w_pg_pulse;
    logic            w_pg_last;

    logic            w_accept;
    logic            w_edge_window;
    logic            w_ticket_edge;
    logic            w_change_edge;
    logic            w_any_edge;

    // The pulse generator latches the first coin amount itself, so the
    // first pulse can appear in the cycle right after start is accepted.
    coin_feeder_pulse_gen #(
        .DW  (DW),
        .GAP (GAP)
    ) u_pulse_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (w_pg_load),
        .lane  (w_pg_lane),
        .count (w_pg_count),
        .pulse (w_pg_pulse),
        .last  (w_pg_last)
    );

    assign w_accept      = (r_state == ST_IDLE) && start;
    assign w_edge_window = (r_state == ST_SEND_TEN) || (r_state == ST_SEND_ONE) ||
                           (r_state == ST_DONE)     || (r_state == ST_COLLECT);
    assign w_ticket_edge = w_edge_window && ticket_pulse && !r_ticket_d;
    assign w_change_edge = w_edge_window && coin_one_out_pulse && !r_change_d;
    assign w_any_edge    = w_ticket_edge || w_change_edge;

    always_comb begin
        w_state_next = r_state;
        w_pg_load    = 1'b0;
        w_pg_lane    = c_lane_ten;
        w_pg_count   = pay_ten;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (pay_ten != '0) begin
                        w_pg_load    = 1'b1;
                        w_pg_lane    = c_lane_ten;
                        w_pg_count   = pay_ten;
                        w_state_next = ST_SEND_TEN;
                    end else if (pay_one != '0) begin
                        w_pg_load    = 1'b1;
                        w_pg_lane    = c_lane_one;
                        w_pg_count   = pay_one;
                        w_state_next = ST_SEND_ONE;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_SEND_TEN: begin
                if (w_pg_last) begin
                    if (r_pay_one != '0) begin
                        w_pg_load    = 1'b1;
                        w_pg_lane    = c_lane_one;
                        w_pg_count   = r_pay_one;
                        w_state_next = ST_SEND_ONE;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_SEND_ONE: begin
                if (w_pg_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                // An edge in the final quiet cycle restarts the wait.
                if (!w_any_edge && (r_quiet == c_quiet_last)) begin
                    w_state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pay_one      <= '0;
            r_ticket_d     <= 1'b0;
            r_change_d     <= 1'b0;
            r_quiet        <= '0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_tickets      <= '0;
            r_change       <= '0;
        end else begin
            r_state        <= w_state_next;
            // Strobes are decoded from the next state so they line up with it.
            r_done         <= (w_state_next == ST_DONE);
            r_busy         <= (w_state_next != ST_IDLE);
            r_result_valid <= (w_state_next == ST_REPORT);
            r_ticket_d     <= ticket_pulse;
            r_change_d     <= coin_one_out_pulse;

            if (w_accept) begin
                r_pay_one <= pay_one;
                r_tickets <= '0;
                r_change  <= '0;
            end else begin
                if (w_ticket_edge && (r_tickets != c_count_max)) begin
                    r_tickets <= r_tickets + DW'(1);
                end
                if (w_change_edge && (r_change != c_count_max)) begin
                    r_change <= r_change + DW'(1);
                end
            end

            if (r_state == ST_DONE) begin
                r_quiet <= '0;
            end else if (r_state == ST_COLLECT) begin
                if (w_any_edge) begin
                    r_quiet <= '0;
                end else if (r_quiet != c_quiet_last) begin
                    r_quiet <= r_quiet + c_qw'(1);
                end
            end
        end
    end

    assign coin_ten_in_pulse = w_pg_pulse[0];
    assign coin_one_in_pulse = w_pg_pulse[1];
    assign done              = r_done;
    assign busy              = r_busy;
    assign result_valid      = r_result_valid;
    assign tickets_rcvd      = r_tickets;
    assign change_rcvd       = r_change;

endmodule : coin_feeder
`default_nettype wire

// File: tb/tb_coin_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_feeder
//  Description : Self-checking bench for coin_feeder. Expected pulse timing is
//                computed arithmetically from the coin counts; returned pulse
//                counts and the report cycle come from the driven waveforms.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coin_feeder;

    localparam int DW      = 8;
    localparam int GAP     = 1;
    localparam int TIMEOUT = 16;
    localparam int MAXC    = 2048;
    localparam int CMAX    = (1 << DW) - 1;
    localparam int PRICE   = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] pay_ten;
    logic [DW-1:0] pay_one;
    logic          ticket_pulse;
    logic          coin_one_out_pulse;
    logic          coin_ten_in_pulse;
    logic          coin_one_in_pulse;
    logic          done;
    logic          busy;
    logic          result_valid;
    logic [DW-1:0] tickets_rcvd;
    logic [DW-1:0] change_rcvd;

    int n_vec = 0;
    int n_err = 0;

    bit tw [MAXC];
    bit cw [MAXC];

    coin_feeder #(
        .DW      (DW),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .pay_ten            (pay_ten),
        .pay_one            (pay_one),
        .ticket_pulse       (ticket_pulse),
        .coin_one_out_pulse (coin_one_out_pulse),
        .coin_ten_in_pulse  (coin_ten_in_pulse),
        .coin_one_in_pulse  (coin_one_in_pulse),
        .done               (done),
        .busy               (busy),
        .result_valid       (result_valid),
        .tickets_rcvd       (tickets_rcvd),
        .change_rcvd        (change_rcvd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ten"},     coin_ten_in_pulse, 0);
        chk({tag, "_one"},     coin_one_in_pulse, 0);
        chk({tag, "_done"},    done, 0);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_rv"},      result_valid, 0);
        chk({tag, "_tickets"}, tickets_rcvd, 0);
        chk({tag, "_change"},  change_rcvd, 0);
    endtask

    task automatic clear_waves();
        for (int i = 0; i < MAXC; i++) begin
            tw[i] = 1'b0;
            cw[i] = 1'b0;
        end
    endtask

    // mode 0: random return waveforms, 1: waveforms preloaded by caller,
    // 2: behave as the vending machine (price PRICE, one ticket).
    // abort_at > 0 asserts reset while driving that cycle and stops there.
    task automatic run_txn(input int a, input int b, input int mode, input int abort_at,
                           input int want_t, input int want_c,
                           output int fin_t, output int fin_c);
        int d, anchor, r, et, ec, vt, vo, k, len, tot;
        bit ph;
        d      = 1 + (a + b) * (GAP + 1);   // cycle carrying done
        anchor = d;                          // last cycle that restarted the quiet wait
        r      = -1;
        et     = 0;
        ec     = 0;
        vt     = 0;
        vo     = 0;
        fin_t  = 0;
        fin_c  = 0;
        if (mode == 0) begin
            len = $urandom_range(d + 30, 2);
            for (int i = 0; i < MAXC; i++) begin
                tw[i] = (i <= len) ? 1'($urandom_range(1, 0)) : 1'b0;
                cw[i] = (i <= len) ? 1'($urandom_range(1, 0)) : 1'b0;
            end
        end else if (mode == 2) begin
            clear_waves();
        end
        // cycle 0: request the purchase
        rst                = 1'b0;
        start              = 1'b1;
        pay_ten            = DW'(a);
        pay_one            = DW'(b);
        ticket_pulse       = tw[0];
        coin_one_out_pulse = cw[0];
        for (int c = 1; c < MAXC - 20 && r < 0; c++) begin
            @(negedge clk);
            k  = (c - 1) / (GAP + 1);
            ph = ((c - 1) % (GAP + 1)) == 0;
            chk("coin_ten", coin_ten_in_pulse, ph && k < a);
            chk("coin_one", coin_one_in_pulse, ph && k >= a && k < a + b);
            chk("done", done, c == d);
            chk("busy", busy, 1);
            chk("result_valid", result_valid, c == anchor + 1 + TIMEOUT);
            if (c == anchor + 1 + TIMEOUT) begin
                r = c;
                chk("tickets_rcvd", tickets_rcvd, et);
                chk("change_rcvd", change_rcvd, ec);
                if (want_t >= 0) chk("tickets_expected", tickets_rcvd, want_t);
                if (want_c >= 0) chk("change_expected", change_rcvd, want_c);
            end
            if (mode == 2) begin
                vt += int'(coin_ten_in_pulse);
                vo += int'(coin_one_in_pulse);
                if (done) begin
                    tot = 10 * vt + vo;
                    if (tot >= PRICE) begin
                        tw[c + 2] = 1'b1;
                        for (int i = 0; i < tot - PRICE; i++) cw[c + 2 + 2 * i] = 1'b1;
                    end
                end
            end
            if (c == abort_at) begin
                rst                = 1'b1;
                start              = 1'b0;
                ticket_pulse       = 1'b0;
                coin_one_out_pulse = 1'b0;
                @(negedge clk);
                chk_all_zero("reset_mid_run");
                return;
            end
            // stray start requests while busy must be ignored
            start              = 1'($urandom_range(1, 0));
            pay_ten            = DW'($urandom);
            pay_one            = DW'($urandom);
            ticket_pulse       = tw[c];
            coin_one_out_pulse = cw[c];
            if (r < 0) begin
                if (tw[c] && !tw[c - 1]) begin
                    if (et < CMAX) et++;
                    if (c > d) anchor = c;
                end
                if (cw[c] && !cw[c - 1]) begin
                    if (ec < CMAX) ec++;
                    if (c > d) anchor = c;
                end
            end
        end
        chk("result_seen", r >= 0, 1);
        start              = 1'b0;
        ticket_pulse       = 1'b0;
        coin_one_out_pulse = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_rv", result_valid, 0);
        chk("hold_tickets", tickets_rcvd, et);
        chk("hold_change", change_rcvd, ec);
        fin_t = et;
        fin_c = ec;
    endtask

    initial begin
        int ft, fc;
        rst                = 1'b1;
        start              = 1'b1;
        pay_ten            = 8'd3;
        pay_one            = 8'd3;
        ticket_pulse       = 1'b0;
        coin_one_out_pulse = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");

        // 2 tens, 3 ones: ten at 1,3; one at 5,7,9; done at 11
        clear_waves();
        run_txn(2, 3, 1, 0, 0, 0, ft, fc);

        // no coins: done at 1, report at 2+TIMEOUT, counts 0
        clear_waves();
        run_txn(0, 0, 1, 0, 0, 0, ft, fc);

        // 3 tickets (one held 3 cycles) and 4 change pulses after done
        clear_waves();
        tw[3] = 1'b1; tw[4] = 1'b1; tw[5] = 1'b1; tw[8] = 1'b1; tw[10] = 1'b1;
        cw[3] = 1'b1; cw[5] = 1'b1; cw[7] = 1'b1; cw[9] = 1'b1;
        run_txn(0, 0, 1, 0, 3, 4, ft, fc);

        // vending machine, price 13, pay 20 -> 1 ticket, 7 change
        run_txn(2, 0, 2, 0, 1, 7, ft, fc);

        // reset during SEND_ONE, then start on the first free edge
        run_txn(1, 3, 0, 5, -1, -1, ft, fc);
        run_txn(1, 1, 0, 0, -1, -1, ft, fc);

        // 300 change edges saturate at the count maximum
        clear_waves();
        for (int i = 0; i < 300; i++) cw[2 + 2 * i] = 1'b1;
        run_txn(0, 0, 1, 0, 0, CMAX, ft, fc);

        for (int n = 0; n < 30; n++) begin
            run_txn($urandom_range(4, 0), $urandom_range(5, 0), 0, 0, -1, -1, ft, fc);
            // idle noise must not disturb the held counts
            repeat ($urandom_range(3, 0)) begin
                ticket_pulse       = 1'($urandom_range(1, 0));
                coin_one_out_pulse = 1'($urandom_range(1, 0));
                @(negedge clk);
                chk("idle_noise_busy", busy, 0);
                chk("idle_noise_tickets", tickets_rcvd, ft);
                chk("idle_noise_change", change_rcvd, fc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_coin_feeder
`default_nettype wire

// File: doc/coin_feeder.md
COIN_FEEDER -- requirements
Module: coin_feeder

Interface
REQ-001 Parameter DW, default 8, width of coin/ticket counts.
REQ-002 Parameter GAP, default 1, low cycles after every emitted pulse (>=1).
REQ-003 Parameter TIMEOUT, default 64, quiet cycles in COLLECT before reporting (>=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  request to run one purchase; sampled only in IDLE.
REQ-007 pay_ten  input  DW  number of ten-unit coins to insert.
REQ-008 pay_one  input  DW  number of one-unit coins to insert.
REQ-009 ticket_pulse  input  1  ticket pulse train returned by vending machine.
REQ-010 coin_one_out_pulse  input  1  change pulse train returned by vending machine.
REQ-011 coin_ten_in_pulse  output  1  ten-coin insertion pulses to vending machine.
REQ-012 coin_one_in_pulse  output  1  one-coin insertion pulses to vending machine.
REQ-013 done  output  1  one-cycle end-of-payment strobe to vending machine.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 result_valid  output  1  one-cycle strobe; tickets_rcvd/change_rcvd final.
REQ-016 tickets_rcvd  output  DW  rising edges counted on ticket_pulse.
REQ-017 change_rcvd  output  DW  rising edges counted on coin_one_out_pulse.

Function
REQ-018 FSM states: IDLE, SEND_TEN, SEND_ONE, DONE, COLLECT, REPORT; all outputs registered.
REQ-019 IDLE with start=1 at edge t: latch pay_ten/pay_one, clear both rcvd counts, enter SEND_TEN (or SEND_ONE if pay_ten=0, or DONE if both 0).
REQ-020 start while busy is ignored; no queuing.
REQ-021 Each coin pulse: output high exactly 1 cycle, then low GAP cycles; first ten pulse high in cycle t+1.
REQ-022 SEND_TEN emits exactly latched pay_ten pulses, then SEND_ONE emits exactly pay_one pulses; ten and one outputs never high together.
REQ-023 After the final GAP of the last pulse, DONE asserts done for exactly 1 cycle; with no coins, done high in cycle t+1.
REQ-024 COLLECT: input rising edge = input high now and low previous cycle (1-cycle history regs, cleared by reset); each edge increments its count.
REQ-025 Edge detection active in SEND_*, DONE and COLLECT states; edges in IDLE/REPORT ignored.
REQ-026 Counts saturate at 2^DW-1; no wrap.
REQ-027 Quiet counter: cleared on entering COLLECT and on any detected edge; when it reaches TIMEOUT-1 move to REPORT.
REQ-028 REPORT: result_valid high 1 cycle, then IDLE; counts hold until next accepted start.
REQ-029 Simultaneous edges on both inputs in one cycle: both counts increment.
REQ-030 Pulse-count arithmetic uses DW-bit down-counters; GAP/TIMEOUT counters sized by $clog2 of parameter +1.

Reset
REQ-031 rst=1 at any edge: state IDLE, all outputs 0, counts 0, history regs 0, latched amounts 0; overrides start and any in-flight pulse.
REQ-032 First start honored on the first edge with rst=0.

Structure
REQ-033 Shared package holds FSM state enum and default DW; vending machine and feeder both import DW from it.
REQ-034 One sub-module natural: pulse_gen (count + GAP -> pulse train, done flag), instantiated once and reloaded per coin type.

Verification
REQ-035 GAP=1, pay_ten=2, pay_one=3, start at t -> ten pulses t+1,t+3; one pulses t+5,t+7,t+9; done at t+11; busy from t+1.
REQ-036 pay_ten=0, pay_one=0 -> done at t+1, no coin pulses; result_valid at t+2+TIMEOUT with counts 0.
REQ-037 Drive 3 ticket and 4 change pulses (1 high/1 low) after done -> result_valid with tickets_rcvd=3, change_rcvd=4; ticket/change held high 3 cycles counts once.
REQ-038 Connected to vendor (price 13, count 1, pay_ten=2, pay_one=0) -> tickets_rcvd=1, change_rcvd=7.
REQ-039 rst asserted mid SEND_ONE -> next cycle all outputs 0, IDLE; second start mid-run ignored; 300 change edges with DW=8 saturate at 255.
